// File: rtl/idle_anim_ctrl_pkg.sv
// Shared types and constants for the idle animation controller.
// Screen geometry, FSM states and the RGB565 pixel type.
package idle_anim_ctrl_pkg;

  localparam int LCD_WIDTH  = 132;
  localparam int LCD_HEIGHT = 132;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    FLUSH,
    DONE
  } state_t;

  typedef logic [15:0] rgb565_t;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/idle_anim_ctrl_if.sv
// ROM address/data and pixel handshake bundle.
// master = animation controller, slave = ROM plus display writer.
interface idle_anim_ctrl_if;
  import idle_anim_ctrl_pkg::*;

  logic [3:0] step;
  logic [7:0] ram_addr_x;
  logic [7:0] ram_addr_y;
  rgb565_t    ram_data;
  rgb565_t    pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       frame_done;

  modport master (
    output step, ram_addr_x, ram_addr_y,
    output pix_data, pix_valid, frame_done,
    input  ram_data, pix_ready
  );

  modport slave (
    input  step, ram_addr_x, ram_addr_y,
    input  pix_data, pix_valid, frame_done,
    output ram_data, pix_ready
  );

endinterface

// File: rtl/idle_raster_cnt.sv
// Raster x/y walker with a per-step frame counter.
// One advance moves one pixel; wrapping the last line bumps the frame.
module idle_raster_cnt
  import idle_anim_ctrl_pkg::*;
#(
  parameter int WIDTH       = LCD_WIDTH,
  parameter int HEIGHT      = LCD_HEIGHT,
  parameter int HOLD_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       advance,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       last_pixel,
  output logic       last_frame
);

  localparam int XW = cnt_w(WIDTH);
  localparam int YW = cnt_w(HEIGHT);
  localparam int FW = cnt_w(HOLD_FRAMES);

  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);
  localparam logic [FW-1:0] FMAX = FW'(HOLD_FRAMES - 1);

  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [FW-1:0] f_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q <= '0;
      y_q <= '0;
      f_q <= '0;
    end else if (clr) begin
      x_q <= '0;
      y_q <= '0;
      f_q <= '0;
    end else if (advance) begin
      if (x_q == XMAX) begin
        x_q <= '0;
        if (y_q == YMAX) begin
          y_q <= '0;
          f_q <= (f_q == FMAX) ? '0 : f_q + 1'b1;
        end else begin
          y_q <= y_q + 1'b1;
        end
      end else begin
        x_q <= x_q + 1'b1;
      end
    end
  end

  assign x          = 8'(x_q);
  assign y          = 8'(y_q);
  assign last_pixel = (x_q == XMAX) && (y_q == YMAX);
  assign last_frame = (f_q == FMAX);

endmodule

// File: rtl/idle_anim_ctrl.sv
// Idle-screen animation scanner: walks the ROM raster per step.
// Define IDLE_ANIM_LOOP_EN to loop steps forever instead of stopping.
module idle_anim_ctrl
  import idle_anim_ctrl_pkg::*;
#(
  parameter int WIDTH       = LCD_WIDTH,
  parameter int HEIGHT      = LCD_HEIGHT,
  parameter int NUM_STEPS   = 4,
  parameter int HOLD_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  output logic              busy,
  idle_anim_ctrl_if.master  bus
);

`ifdef IDLE_ANIM_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam logic [3:0] SMAX = 4'(NUM_STEPS - 1);

  state_t     state, state_n;
  logic [3:0] step_q;
  rgb565_t    pix_q;
  logic       valid_q;
  logic       done_q;
  logic       load, accept, clr, advance;
  logic       last_pixel, last_frame, last_step;

  idle_raster_cnt #(
    .WIDTH       (WIDTH),
    .HEIGHT      (HEIGHT),
    .HOLD_FRAMES (HOLD_FRAMES)
  ) u_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .advance    (advance),
    .x          (bus.ram_addr_x),
    .y          (bus.ram_addr_y),
    .last_pixel (last_pixel),
    .last_frame (last_frame)
  );

  assign last_step = (step_q == SMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    load    = 1'b0;
    accept  = 1'b0;
    clr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_n = SCAN;
          clr     = 1'b1;
        end
      end
      SCAN: begin
        load = !valid_q || bus.pix_ready;
        if (load && last_pixel) state_n = FLUSH;
      end
      FLUSH: begin
        if (bus.pix_ready) begin
          accept  = 1'b1;
          state_n = SCAN;
          if (last_frame && last_step && !LOOP)
            state_n = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_n = SCAN;
          clr     = 1'b1;
        end
      end
    endcase
    if (stop) begin
      state_n = IDLE;
      clr     = 1'b1;
      load    = 1'b0;
      accept  = 1'b0;
    end
  end

  // The final pixel holds its address until FLUSH sees it accepted.
  assign advance = (load && !last_pixel) || accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_q  <= '0;
      pix_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= accept;
      if (clr) begin
        step_q  <= '0;
        pix_q   <= '0;
        valid_q <= 1'b0;
      end else if (load) begin
        pix_q   <= bus.ram_data;
        valid_q <= 1'b1;
      end else if (accept) begin
        pix_q   <= '0;
        valid_q <= 1'b0;
        if (last_frame) begin
          if (!last_step)  step_q <= step_q + 4'd1;
          else if (LOOP)   step_q <= '0;
        end
      end
    end
  end

  assign bus.step       = step_q;
  assign bus.pix_data   = pix_q;
  assign bus.pix_valid  = valid_q;
  assign bus.frame_done = done_q;
  assign busy = (state == SCAN) || (state == FLUSH);

endmodule

// File: tb/tb_idle_anim_ctrl.sv
// Bench for idle_anim_ctrl: raster scoreboard with random backpressure.
// Honors IDLE_ANIM_LOOP_EN for the expected frame sequence.
module tb_idle_anim_ctrl;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int NS = 2;
  localparam int HF = 2;
`ifdef IDLE_ANIM_LOOP_EN
  localparam int TOT = 5;
`else
  localparam int TOT = 4;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic stop;
  logic busy;

  idle_anim_ctrl_if bus ();

  idle_anim_ctrl #(
    .WIDTH       (W),
    .HEIGHT      (H),
    .NUM_STEPS   (NS),
    .HOLD_FRAMES (HF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.ram_data = 16'(int'(bus.step) * 256 +
                            int'(bus.ram_addr_y) * 16 +
                            int'(bus.ram_addr_x));

  int          errors = 0;
  int          checks = 0;
  int          fd_cnt = 0;
  int          cyc = 0;
  logic [15:0] q[$];
  logic        prev_stall = 1'b0;
  logic [15:0] prev_data = '0;
  logic        prev_fd = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_valid"}, 32'(bus.pix_valid), 0);
    chk({tag, "_fd"}, 32'(bus.frame_done), 0);
    chk({tag, "_x"}, 32'(bus.ram_addr_x), 0);
    chk({tag, "_y"}, 32'(bus.ram_addr_y), 0);
  endtask

  // Entered and left at a negedge; consumes until nfr frame_done pulses.
  task automatic stream(input bit rnd, input int nfr);
    int seen = 0;
    int first = -1;
    int last = -1;
    logic rdy;
    for (int b = 0; b < 400; b++) begin
      if (prev_stall) begin
        chk("stall_data", 32'(bus.pix_data), 32'(prev_data));
        chk("stall_valid", 32'(bus.pix_valid), 1);
      end
      if (bus.frame_done) begin
        chk("fd_pulse", 32'(prev_fd), 0);
        seen++;
        fd_cnt++;
      end
      prev_fd = bus.frame_done;
      rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.pix_ready = rdy;
      if (bus.pix_valid && rdy) begin
        if (q.size() == 0) chk("extra_pixel", 32'(bus.pix_data), 32'hdead);
        else chk("pixel", 32'(bus.pix_data), 32'(q.pop_front()));
        if (first < 0) first = cyc;
        last = cyc;
        prev_stall = 1'b0;
      end else begin
        prev_stall = bus.pix_valid;
        prev_data  = bus.pix_data;
      end
      if (seen == nfr) break;
      @(negedge clk);
      cyc++;
    end
    chk("stream_frames", 32'(seen), 32'(nfr));
    if (!rnd) chk("no_gap", 32'(last - first), 32'(W * H - 1));
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    bus.pix_ready = 1'b0;
    for (int s = 0; s < NS; s++)
      for (int f = 0; f < HF; f++)
        for (int y = 0; y < H; y++)
          for (int x = 0; x < W; x++)
            q.push_back(16'(s * 256 + y * 16 + x));
    for (int k = NS * HF; k < TOT; k++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          q.push_back(16'(y * 16 + x));

    #12;
    chk_idle("reset");
    chk("reset_step", 32'(bus.step), 0);
    chk("reset_data", 32'(bus.pix_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_autostart", 32'(busy), 0);

    start = 1'b1;
    bus.pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("after_start_busy", 32'(busy), 1);
    chk("after_start_valid", 32'(bus.pix_valid), 0);
    @(negedge clk);
    chk("valid_rise", 32'(bus.pix_valid), 1);
    stream(1'b0, 1);
    @(negedge clk);
    stream(1'b1, TOT - 1);
    chk("fd_total", 32'(fd_cnt), 32'(TOT));
    chk("queue_empty", 32'(q.size()), 0);
`ifdef IDLE_ANIM_LOOP_EN
    chk("loop_busy", 32'(busy), 1);
`else
    chk("done_busy", 32'(busy), 0);
    chk("done_step", 32'(bus.step), 32'(NS - 1));
    chk("done_valid", 32'(bus.pix_valid), 0);
    @(negedge clk);
    chk_idle("done");
    chk("done_data", 32'(bus.pix_data), 0);
`endif

    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk_idle("stop_end");
    chk("stop_end_step", 32'(bus.step), 0);

    start = 1'b1;
    bus.pix_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      bit hit = 1'b0;
      for (int b = 0; b < 20 && !hit; b++) begin
        @(negedge clk);
        if (bus.pix_valid && bus.pix_data == 16'h0012) hit = 1'b1;
      end
      chk("reach_2_1", 32'(hit), 1);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk_idle("stop_mid");
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("resume_step", 32'(bus.step), 0);
    chk("resume_busy", 32'(busy), 1);
    @(negedge clk);
    chk("resume_p0", 32'(bus.pix_data), 32'h0000);
    @(negedge clk);
    chk("resume_p1", 32'(bus.pix_data), 32'h0001);
    @(negedge clk);

    #2 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_data", 32'(bus.pix_data), 0);
    chk("async_rst_step", 32'(bus.step), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("both_busy", 32'(busy), 0);
    @(negedge clk);
    chk("both_busy2", 32'(busy), 0);
    chk("both_valid", 32'(bus.pix_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
